level_meter: RTL

Multi-channel audio level meter with LED bargraph outputs. It replaces the single-channel EMA/abs/log10/bargraph chain hung off the I2S decoder. It takes CHANNELS signed PCM samples on each sample strobe and processes them time-multiplexed through one shared datapath. Per channel it produces an envelope (instant attack, exponential release), a ~6 dB/LED thermometer bar, and an optional peak-hold dot.

---
 rtl/level_meter_pkg.sv | 40 ++++
 rtl/msb_encoder.sv | 19 +
 rtl/level_meter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/level_meter_pkg.sv
// Shared types and helpers for the multi-channel level meter datapath.
package level_meter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAbs,
    StEnv,
    StMap,
    StDone
  } state_e;

  // Level width for the default 8-LED bar; the top derives its own from LEDS.
  localparam int unsigned DefaultLeds = 8;
  localparam int unsigned LW = $clog2(DefaultLeds + 1);

  // Index of the highest set bit among the low `width` bits; 0 when none set.
  function automatic int unsigned msb_index(input logic [31:0] value, input int unsigned width);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width && value[i[4:0]]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

  // Bits [lvl-1:0] set, limited to `leds` bits.
  function automatic logic [31:0] thermometer(input int unsigned lvl, input int unsigned leds);
    logic [31:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < lvl && i < leds) begin
        mask[i[4:0]] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/msb_encoder.sv
// Combinational priority encoder: position of the highest set bit plus a zero flag.
module msb_encoder
  import level_meter_pkg::*;
#(
  parameter int unsigned WIDTH = 15
) (
  input  logic [WIDTH-1:0]         value,
  output logic [$clog2(WIDTH)-1:0] msb,
  output logic                     zero
);

  localparam int unsigned Mw = $clog2(WIDTH);

  always_comb begin
    zero = (value == '0);
    msb  = Mw'(msb_index(32'(value), WIDTH));
  end

endmodule

// File: rtl/level_meter.sv
// Time-multiplexed multi-channel level meter: envelope, ~6 dB/LED bar and peak hold.
// Define LEVEL_METER_PEAK_DOT_EN to light a floating peak dot above the bar.
module level_meter
  import level_meter_pkg::*;
#(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned LEDS         = 8,
  parameter int unsigned DECAY_SHIFT  = 4,
  parameter int unsigned HOLD_SAMPLES = 24000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  sample_clk,
  input  logic [CHANNELS*WIDTH-1:0]             samples,
  output logic [CHANNELS*LEDS-1:0]              bar,
  output logic [CHANNELS*$clog2(LEDS+1)-1:0]    level,
  output logic [CHANNELS*$clog2(LEDS+1)-1:0]    peak_level,
  output logic                                  valid,
  output logic                                  overrun
);

  localparam int unsigned Lw     = $clog2(LEDS + 1);
  localparam int unsigned Aw     = WIDTH - 1;
  localparam int unsigned Mw     = $clog2(Aw);
  localparam int unsigned Hw     = $clog2(HOLD_SAMPLES + 1);
  localparam int unsigned Cw     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int          Offset = int'(WIDTH) - 2 - int'(LEDS);
  localparam logic [CHANNELS*LEDS-1:0] BarOff = ACTIVE_LOW ? '1 : '0;

  state_e state_q, state_d;
  logic [Cw-1:0] ch_q, ch_d;
  logic          last_ch;

  logic [CHANNELS*WIDTH-1:0] samples_q;
  logic [Aw-1:0]             abs_q;
  logic [Aw-1:0]             env_q  [CHANNELS];
  logic [Lw-1:0]             lvl_q  [CHANNELS];
  logic [Lw-1:0]             peak_q [CHANNELS];
  logic [Hw-1:0]             hold_q [CHANNELS];

  logic [CHANNELS*LEDS-1:0] bar_q, bar_next;
  logic [CHANNELS*Lw-1:0]   level_q, level_next;
  logic [CHANNELS*Lw-1:0]   peak_out_q, peak_next;
  logic                     overrun_q;

  // FSM
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    last_ch = (32'(ch_q) == CHANNELS - 1);
    unique case (state_q)
      StIdle: begin
        if (sample_clk) begin
          state_d = StAbs;
          ch_d    = '0;
        end
      end
      StAbs: state_d = StEnv;
      StEnv: state_d = StMap;
      StMap: begin
        if (last_ch) begin
          state_d = StDone;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = StAbs;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ABS: magnitude, with the most negative code saturating to full scale
  logic [WIDTH-1:0] x, neg;
  logic [Aw-1:0]    abs_d;

  always_comb begin
    x   = samples_q[32'(ch_q)*WIDTH +: WIDTH];
    neg = ~x + 1'b1;
    if (!x[WIDTH-1]) begin
      abs_d = x[Aw-1:0];
    end else if (neg[WIDTH-1]) begin
      abs_d = '1;
    end else begin
      abs_d = neg[Aw-1:0];
    end
  end

  // ENV: instant attack, exponential release that always reaches zero
  logic [Aw-1:0] env_cur, decay, env_new;

  always_comb begin
    env_cur = env_q[ch_q];
    decay   = env_cur >> DECAY_SHIFT;
    if (abs_q > env_cur) begin
      env_new = abs_q;
    end else if (decay == '0 && env_cur != '0) begin
      env_new = env_cur - 1'b1;
    end else begin
      env_new = env_cur - decay;
    end
  end

  // MAP: log2 level from the updated envelope, then peak hold
  logic [Mw-1:0] msb;
  logic          env_zero;
  int            lvl_raw;
  logic [Lw-1:0] lvl_new, peak_cur, peak_new;
  logic [Hw-1:0] hold_cur, hold_new;

  msb_encoder #(
    .WIDTH(Aw)
  ) u_msb (
    .value(env_cur),
    .msb  (msb),
    .zero (env_zero)
  );

  always_comb begin
    lvl_raw = int'(msb) - Offset;
    if (env_zero || lvl_raw <= 0) begin
      lvl_new = '0;
    end else if (lvl_raw >= int'(LEDS)) begin
      lvl_new = Lw'(LEDS);
    end else begin
      lvl_new = Lw'(lvl_raw);
    end

    peak_cur = peak_q[ch_q];
    hold_cur = hold_q[ch_q];
    if (lvl_new >= peak_cur) begin
      peak_new = lvl_new;
      hold_new = Hw'(HOLD_SAMPLES);
    end else if (hold_cur != '0) begin
      peak_new = peak_cur;
      hold_new = hold_cur - 1'b1;
    end else begin
      peak_new = peak_cur - 1'b1;
      hold_new = Hw'(HOLD_SAMPLES);
    end
  end

  // Output image for all channels, including the channel finishing this cycle,
  // so bar/level/peak_level become visible together with valid.
  logic [Lw-1:0]   lvl_all  [CHANNELS];
  logic [Lw-1:0]   peak_all [CHANNELS];
  logic [LEDS-1:0] mask;

  always_comb begin
    bar_next   = '0;
    level_next = '0;
    peak_next  = '0;
    mask       = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      lvl_all[c]  = lvl_q[c];
      peak_all[c] = peak_q[c];
    end
    lvl_all[ch_q]  = lvl_new;
    peak_all[ch_q] = peak_new;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      mask = LEDS'(thermometer(32'(lvl_all[c]), LEDS));
`ifdef LEVEL_METER_PEAK_DOT_EN
      if (peak_all[c] > lvl_all[c] && peak_all[c] != '0) begin
        mask = mask | LEDS'(thermometer(32'(peak_all[c]), LEDS) &
                            ~thermometer(32'(peak_all[c]) - 1, LEDS));
      end
`endif
      bar_next[c*LEDS +: LEDS] = ACTIVE_LOW ? ~mask : mask;
      level_next[c*Lw +: Lw]   = lvl_all[c];
      peak_next[c*Lw +: Lw]    = peak_all[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      samples_q  <= '0;
      abs_q      <= '0;
      overrun_q  <= 1'b0;
      bar_q      <= BarOff;
      level_q    <= '0;
      peak_out_q <= '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        env_q[c]  <= '0;
        lvl_q[c]  <= '0;
        peak_q[c] <= '0;
        hold_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      if (state_q == StIdle && sample_clk) begin
        samples_q <= samples;
      end
      if (state_q != StIdle && sample_clk) begin
        overrun_q <= 1'b1;
      end
      if (state_q == StAbs) begin
        abs_q <= abs_d;
      end
      if (state_q == StEnv) begin
        env_q[ch_q] <= env_new;
      end
      if (state_q == StMap) begin
        lvl_q[ch_q]  <= lvl_new;
        peak_q[ch_q] <= peak_new;
        hold_q[ch_q] <= hold_new;
        if (last_ch) begin
          bar_q      <= bar_next;
          level_q    <= level_next;
          peak_out_q <= peak_next;
        end
      end
    end
  end

  assign bar        = bar_q;
  assign level      = level_q;
  assign peak_level = peak_out_q;
  assign valid      = (state_q == StDone);
  assign overrun    = overrun_q;

endmodule
